// File: rtl/escalonador_display.sv
// Seven-segment scan controller: slot rotation plus scoreboard/timer phases.
// Optional ESCALONADOR_ZERO_BLANK_EN suppresses leading-zero tens digits.
module escalonador_display #(
  parameter int CLK_HZ        = 50000000,
  parameter int SCAN_HZ       = 480,
  parameter int PHASE_SECONDS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] placar_t1,
  input  logic [7:0] placar_t2,
  input  logic [7:0] cronometro,
  input  logic       travar,
  output logic [3:0] anodo,
  output logic [3:0] digito,
  output logic       fase
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PF  = PHASE_SECONDS * SCAN_HZ / 4;
  localparam int PW  = $clog2(DIV);
  localparam int FW  = (PF > 1) ? $clog2(PF) : 1;

  localparam logic [PW-1:0] PRE_TOP = PW'(DIV - 1);
  localparam logic [FW-1:0] FRM_TOP = FW'(PF - 1);

  logic [PW-1:0] presc;
  logic [1:0]    slot;
  logic [FW-1:0] frames;
  logic          ph;
  logic          tick;
  logic          frame_end;
  logic [3:0]    an_n;
  logic [3:0]    dg_n;
  logic          blank;

  assign tick      = (presc == PRE_TOP);
  assign frame_end = tick && (slot == 2'd3);

  always_comb begin
    an_n = 4'b1111;
    dg_n = 4'h0;
    unique case ({ph, slot})
      3'b000: begin an_n = 4'b0111; dg_n = placar_t1[7:4];  end
      3'b001: begin an_n = 4'b1011; dg_n = placar_t1[3:0];  end
      3'b010: begin an_n = 4'b1101; dg_n = placar_t2[7:4];  end
      3'b011: begin an_n = 4'b1110; dg_n = placar_t2[3:0];  end
      3'b101: begin an_n = 4'b1011; dg_n = cronometro[7:4]; end
      3'b110: begin an_n = 4'b1101; dg_n = cronometro[3:0]; end
      default: begin an_n = 4'b1111; dg_n = 4'h0; end
    endcase
  end

`ifdef ESCALONADOR_ZERO_BLANK_EN
  always_comb begin
    blank = 1'b0;
    unique case ({ph, slot})
      3'b000:  blank = (placar_t1[7:4] == 4'h0);
      3'b010:  blank = (placar_t2[7:4] == 4'h0);
      3'b101:  blank = (cronometro[7:4] == 4'h0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Outputs load the current slot; slot then points at the next one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot   <= 2'd0;
      anodo  <= 4'b1111;
      digito <= 4'h0;
      fase   <= 1'b0;
    end else if (tick) begin
      slot   <= slot + 2'd1;
      anodo  <= blank ? 4'b1111 : an_n;
      digito <= blank ? 4'h0 : dg_n;
      fase   <= ph;
    end
  end

  // Phase flips on the slot-3 load, so the next slot-0 load starts the new phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frames <= '0;
      ph     <= 1'b0;
    end else if (frame_end && !travar) begin
      if (frames == FRM_TOP) begin
        frames <= '0;
        ph     <= ~ph;
      end else begin
        frames <= frames + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_escalonador_display.sv
// Bench for escalonador_display: load-count reference model,
// directed literal points and randomized inputs/travar/reset.
module tb_escalonador_display;

  localparam int CLK_HZ = 16;
  localparam int SCAN_HZ = 8;
  localparam int PHS = 2;
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PF = PHS * SCAN_HZ / 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] placar_t1 = 8'h47;
  logic [7:0] placar_t2 = 8'h93;
  logic [7:0] cronometro = 8'h58;
  logic       travar = 1'b0;
  logic [3:0] anodo;
  logic [3:0] digito;
  logic       fase;

  int n_chk = 0;
  int n_fail = 0;

  escalonador_display #(
    .CLK_HZ(CLK_HZ),
    .SCAN_HZ(SCAN_HZ),
    .PHASE_SECONDS(PHS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .placar_t1(placar_t1),
    .placar_t2(placar_t2),
    .cronometro(cronometro),
    .travar(travar),
    .anodo(anodo),
    .digito(digito),
    .fase(fase)
  );

  always #5 clock = ~clock;

  function automatic logic zb(input logic [3:0] tens);
`ifdef ESCALONADOR_ZERO_BLANK_EN
    return tens == 4'h0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] view(input logic p, input int s);
    logic [7:0] r;
    r = {4'b1111, 4'h0};
    if (!p) begin
      case (s)
        0: r = zb(placar_t1[7:4]) ? 8'hF0 : {4'b0111, placar_t1[7:4]};
        1: r = {4'b1011, placar_t1[3:0]};
        2: r = zb(placar_t2[7:4]) ? 8'hF0 : {4'b1101, placar_t2[7:4]};
        default: r = {4'b1110, placar_t2[3:0]};
      endcase
    end else begin
      case (s)
        1: r = zb(cronometro[7:4]) ? 8'hF0 : {4'b1011, cronometro[7:4]};
        2: r = {4'b1101, cronometro[3:0]};
        default: r = 8'hF0;
      endcase
    end
    return r;
  endfunction

  // Reference: edges since reset -> load number -> slot and frame.
  int         edges;
  int         frames;
  logic       ph;
  logic [7:0] ev;
  logic       ef;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      edges  <= 0;
      frames <= 0;
      ph     <= 1'b0;
      ev     <= 8'hF0;
      ef     <= 1'b0;
    end else begin
      edges <= edges + 1;
      if (((edges + 1) % DIV) == 0) begin
        ev <= view(ph, ((edges + 1) / DIV - 1) % 4);
        ef <= ph;
        if (((((edges + 1) / DIV - 1) % 4) == 3) && !travar) begin
          if (frames == PF - 1) begin
            frames <= 0;
            ph     <= ~ph;
          end else begin
            frames <= frames + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("model_anodo", anodo, ev[7:4]);
    chk("model_digito", digito, ev[3:0]);
    chk("model_fase", {3'b0, fase}, {3'b0, ef});
  end

  task automatic goto(input int e);
    int guard;
    guard = 0;
    while (edges < e && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    if (edges < e) begin
      n_chk++;
      n_fail++;
      $display("FAIL goto_timeout: got %0d expected %0d", edges, e);
    end
  endtask

  task automatic lit(input string nm, input logic [3:0] a,
                     input logic [3:0] d, input logic f);
    chk({nm, "_an"}, anodo, a);
    chk({nm, "_dg"}, digito, d);
    chk({nm, "_fs"}, {3'b0, fase}, {3'b0, f});
  endtask

  initial begin
    repeat (3) @(negedge clock);
    lit("in_reset", 4'b1111, 4'h0, 1'b0);
    reset = 1'b1;
    goto(1);
    lit("pre_first", 4'b1111, 4'h0, 1'b0);
    goto(2);
    lit("s0", 4'b0111, 4'h4, 1'b0);
    goto(3);
    lit("s0_hold", 4'b0111, 4'h4, 1'b0);
    goto(4);
    lit("s1", 4'b1011, 4'h7, 1'b0);
    goto(6);
    lit("s2", 4'b1101, 4'h9, 1'b0);
    goto(8);
    lit("s3", 4'b1110, 4'h3, 1'b0);
    goto(32);
    lit("last_sb", 4'b1110, 4'h3, 1'b0);
    goto(34);
    lit("t0", 4'b1111, 4'h0, 1'b1);
    goto(36);
    lit("t1", 4'b1011, 4'h5, 1'b1);
    goto(38);
    lit("t2", 4'b1101, 4'h8, 1'b1);
    goto(40);
    lit("t3", 4'b1111, 4'h0, 1'b1);
    goto(66);
    lit("back_sb", 4'b0111, 4'h4, 1'b0);
    goto(94);
    travar = 1'b1;
    goto(96);
    travar = 1'b0;
    goto(98);
    lit("held", 4'b0111, 4'h4, 1'b0);
    goto(106);
    lit("released", 4'b1111, 4'h0, 1'b1);
    goto(110);
    lit("pre_rst", 4'b1101, 4'h8, 1'b1);
    #2 reset = 1'b0;
    #1 lit("async_rst", 4'b1111, 4'h0, 1'b0);
    placar_t1 = 8'h05;
    @(negedge clock);
    reset = 1'b1;
    goto(2);
`ifdef ESCALONADOR_ZERO_BLANK_EN
    lit("zb_s0", 4'b1111, 4'h0, 1'b0);
`else
    lit("zb_s0", 4'b0111, 4'h0, 1'b0);
`endif
    goto(4);
    lit("zb_s1", 4'b1011, 4'h5, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if ($urandom_range(3) == 0) placar_t1 = 8'($urandom);
      if ($urandom_range(3) == 0) placar_t2 = 8'($urandom);
      if ($urandom_range(3) == 0) cronometro = 8'($urandom);
      travar = ($urandom_range(5) == 0);
      if ($urandom_range(799) == 0) begin
        #2 reset = 1'b0;
        #1 lit("rnd_rst", 4'b1111, 4'h0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
      end
    end
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
